sensor_conditioner: RTL and testbench
=====================================

Name: sensor_conditioner

Overview:
Upstream stage of fsm_sequence. Takes the two raw level-sensor lines (bit0 = lower sensor I, bit1 = upper sensor S) and synchronises and debounces each one. It then checks the sensor pair for plausibility before presenting a clean sensors[1:0] bus to the pump FSM. A sticky fault flag is raised when the physically impossible pattern 2'b10 (upper wet, lower dry) persists.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised bit must differ from its stable value before the stable value flips; legal range >= 1.
FAULT_CYCLES, 8, consecutive cycles the debounced pair must read 2'b10 before fault asserts; legal range >= 1.

Ports:
clock  input  1  system clock, rising-edge active.
reset  input  1  asynchronous, active-low reset.
raw_sensors  input  2  unsynchronised sensor lines, bit1 = S, bit0 = I.
fault_clear  input  1  level; releases the FAULT state when the debounced pair is plausible.
sensors  output  2  conditioned sensor pair to fsm_sequence.
changed  output  1  one-cycle pulse on the cycle sensors takes a new value.
fault  output  1  sticky implausibility flag.
state  output  2  plausibility FSM state, for debug/waveforms.

Behaviour:
- Reset (reset = 0, asynchronous) clears all registers: sync flops, stable bits and counters = 0; sensors = 2'b00, changed = 0, fault = 0, state = VALID.
- Per bit, synchroniser: two-flop chain, raw -> sync1 -> sync2.
- Per bit, debounce:
  - If sync2 == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, stable <= sync2 and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES + 1); it never wraps.
- Latency: a new raw value first sampled at edge k.
  - stable updates at edge k + DEBOUNCE_CYCLES + 1.
  - sensors updates at edge k + DEBOUNCE_CYCLES + 2.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches stable. Each bit is debounced independently, and both bits may flip on the same edge.
- Plausibility FSM, evaluated on pair P = {stable1, stable0}; encodings VALID = 0, SUSPECT = 1, FAULT = 2 (3 unused, decodes to VALID).
  - VALID:
    - If P != 2'b10: sensors <= P; changed = 1 for exactly one cycle iff P differs from the current sensors.
    - If P == 2'b10: go to SUSPECT, fault counter <= 1, sensors holds.
  - SUSPECT: sensors holds the last plausible value.
    - If P != 2'b10: go to VALID, and sensors <= P with the normal changed rule in that same edge.
    - If P == 2'b10: counter increments; when counter == FAULT_CYCLES, go to FAULT and set fault = 1.
  - FAULT: sensors holds the last plausible value; fault stays 1.
    - Exit to VALID only on an edge where fault_clear = 1 and P != 2'b10. On that edge fault <= 0 and sensors <= P (changed rule applies).
    - fault_clear while P == 2'b10 is ignored.
    - fault_clear in VALID or SUSPECT has no effect.
- changed is never asserted in SUSPECT or FAULT.
- Reset mid-operation: all counters and the FSM return to reset values immediately; no pulse is produced on release.
- After reset release, the first possible sensors change occurs DEBOUNCE_CYCLES + 2 edges after the raw value is sampled.

Decomposition:
- Shared package sensor_pkg:
  - FSM state localparams (VALID / SUSPECT / FAULT) and their 2-bit width.
  - Pattern constant IMPOSSIBLE = 2'b10.
  - Default debounce and fault constants.
  - Shared with fsm_sequence, which also treats 2'b10 as impossible.
- Sub-module debounce_bit (synchroniser + counter + stable flop, parameter DEBOUNCE_CYCLES), instantiated twice.
- The plausibility FSM lives in sensor_conditioner.

Test Plan:
1. Reset with raw = 2'b11, then release; raw held at 2'b11 -> sensors = 00 until edge 6 after the first sample (D = 4), then 11 with a single changed pulse.
2. raw bit0 glitch to 1 for 3 cycles from 00 -> sensors stays 00, changed never asserts; the same glitch held 4 cycles -> sensors = 01, one changed pulse.
3. From sensors = 01, raw = 10 for 5 cycles then 11 -> state VALID -> SUSPECT -> VALID, fault stays 0, sensors 01 -> 11 with one pulse, never showing 10.
4. From sensors = 01, raw = 10 held -> fault = 1 exactly 8 cycles after P becomes 10; sensors holds 01; fault_clear pulse while P = 10 is ignored.
5. From 4, raw = 00, then fault_clear = 1 after P = 00 -> state VALID, fault = 0, sensors = 00 with one changed pulse on that edge.
6. Assert reset in SUSPECT with the counter mid-count -> sensors = 00, fault = 0, state = VALID immediately (asynchronously, not waiting for an edge); no changed pulse after release.

Source files
------------

// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_pkg
// Purpose  : Shared definitions for the level-sensor conditioning path and the
//            downstream pump sequencer: plausibility FSM states, the
//            physically impossible sensor pattern and default timing values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    localparam int STATE_W = 2;

    // Plausibility FSM states. Encoding 3 is unused and decodes to VALID.
    typedef enum logic [STATE_W-1:0] {
        ST_VALID   = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // Upper sensor wet while lower sensor dry cannot happen physically.
    localparam logic [1:0] IMPOSSIBLE = 2'b10;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_FAULT_CYCLES    = 8;

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Purpose  : Two-flop synchroniser followed by a run-length debouncer for one
//            sensor line. The stable value flips only after the synchronised
//            value has differed from it on DEBOUNCE_CYCLES consecutive edges.
// Ports    : clock  - system clock, rising edge
//            reset  - asynchronous active-low reset
//            raw    - unsynchronised sensor line
//            stable - debounced value
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the edge before the flip; the flip edge itself is the
    // DEBOUNCE_CYCLES-th differing edge, so the counter never exceeds this.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sensor_conditioner
// Purpose  : Synchronises and debounces the two raw level-sensor lines, then
//            screens the pair for plausibility before handing a clean bus to
//            the pump sequencer. A persistent 2'b10 pattern raises a sticky
//            fault that only fault_clear (with a plausible pair) releases.
// Ports    : clock       - system clock, rising edge
//            reset       - asynchronous active-low reset
//            raw_sensors - raw lines, bit1 = upper S, bit0 = lower I
//            fault_clear - level request to leave the fault state
//            sensors     - conditioned sensor pair
//            changed     - one-cycle pulse when sensors takes a new value
//            fault       - sticky implausibility flag
//            state       - plausibility FSM state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FAULT_CYCLES    = DEFAULT_FAULT_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         raw_sensors,
    input  logic               fault_clear,
    output logic [1:0]         sensors,
    output logic               changed,
    output logic               fault,
    output logic [STATE_W-1:0] state
);

    localparam int              FCNT_W   = $clog2(FAULT_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FAULT_CYCLES);
    // With a one-cycle threshold the first implausible sample already faults.
    localparam logic            FAULT_ON_FIRST = (FAULT_CYCLES == 1);

    logic [1:0] w_pair;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock (clock),
                .reset (reset),
                .raw   (raw_sensors[i]),
                .stable(w_pair[i])
            );
        end
    endgenerate

    state_t             r_state,   w_state_nxt;
    logic [FCNT_W-1:0]  r_fcnt,    w_fcnt_nxt;
    logic [1:0]         r_sensors, w_sensors_nxt;
    logic               r_changed, w_changed_nxt;
    logic               r_fault,   w_fault_nxt;
    logic               w_plausible;
    logic [FCNT_W-1:0]  w_fcnt_inc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_VALID;
            r_fcnt    <= '0;
            r_sensors <= 2'b00;
            r_changed <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fcnt    <= w_fcnt_nxt;
            r_sensors <= w_sensors_nxt;
            r_changed <= w_changed_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    assign w_plausible = (w_pair != IMPOSSIBLE);
    // Only used in SUSPECT, where r_fcnt < FAULT_CYCLES, so it cannot wrap.
    assign w_fcnt_inc  = r_fcnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_fcnt_nxt    = r_fcnt;
        w_sensors_nxt = r_sensors;
        w_changed_nxt = 1'b0;
        w_fault_nxt   = r_fault;

        case (r_state)
            ST_SUSPECT: begin
                if (w_plausible) begin
                    w_state_nxt   = ST_VALID;
                    w_fcnt_nxt    = '0;
                    w_sensors_nxt = w_pair;
                    w_changed_nxt = (w_pair != r_sensors);
                end else begin
                    w_fcnt_nxt = w_fcnt_inc;
                    if (w_fcnt_inc == FCNT_MAX) begin
                        w_state_nxt = ST_FAULT;
                        w_fault_nxt = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clear && w_plausible) begin
                    w_state_nxt   = ST_VALID;
                    w_fcnt_nxt    = '0;
                    w_fault_nxt   = 1'b0;
                    w_sensors_nxt = w_pair;
                    w_changed_nxt = (w_pair != r_sensors);
                end
            end
            default: begin
                // VALID, and the unused encoding which behaves as VALID.
                if (w_plausible) begin
                    w_state_nxt   = ST_VALID;
                    w_fcnt_nxt    = '0;
                    w_sensors_nxt = w_pair;
                    w_changed_nxt = (w_pair != r_sensors);
                end else begin
                    w_fcnt_nxt  = FCNT_W'(1);
                    w_state_nxt = FAULT_ON_FIRST ? ST_FAULT : ST_SUSPECT;
                    w_fault_nxt = FAULT_ON_FIRST;
                end
            end
        endcase
    end

    assign sensors = r_sensors;
    assign changed = r_changed;
    assign fault   = r_fault;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_conditioner
// Purpose  : Self-checking bench for sensor_conditioner. A behavioural model
//            (history window debounce, run-length plausibility tracking) is
//            compared against the DUT on every falling edge; directed
//            scenarios add literal expectations at key cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_conditioner;

    localparam int D = 4;
    localparam int F = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] raw_sensors = 2'b00;
    logic       fault_clear = 1'b0;
    logic [1:0] sensors;
    logic       changed;
    logic       fault;
    logic [1:0] state;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .FAULT_CYCLES   (F)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .raw_sensors(raw_sensors),
        .fault_clear(fault_clear),
        .sensors    (sensors),
        .changed    (changed),
        .fault      (fault),
        .state      (state)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // sync2 lags raw by two edges; a bit's stable value flips once the last
    // D synchronised samples all disagree with it. The pair is screened by
    // counting consecutive implausible samples.
    // ------------------------------------------------------------------
    logic [1:0] m_sync1   = 2'b00;
    logic [1:0] m_sync2   = 2'b00;
    logic [1:0] m_stable  = 2'b00;
    logic [1:0] m_sensors = 2'b00;
    logic       m_changed = 1'b0;
    logic       m_fault   = 1'b0;
    int         m_bad     = 0;
    logic       hist [2][D];

    task automatic model_reset();
        m_sync1 = 2'b00; m_sync2 = 2'b00; m_stable = 2'b00;
        m_sensors = 2'b00; m_changed = 1'b0; m_fault = 1'b0; m_bad = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < D; i++) hist[b][i] = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] p;
        logic       all_diff;
        p = m_stable;
        m_changed = 1'b0;
        if (m_fault) begin
            if (fault_clear && p != 2'b10) begin
                m_fault   = 1'b0;
                m_bad     = 0;
                m_changed = (p != m_sensors);
                m_sensors = p;
            end
        end else if (p == 2'b10) begin
            m_bad++;
            if (m_bad >= F) m_fault = 1'b1;
        end else begin
            m_bad     = 0;
            m_changed = (p != m_sensors);
            m_sensors = p;
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = D - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = m_sync2[b];
            all_diff = 1'b1;
            for (int i = 0; i < D; i++)
                if (hist[b][i] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) m_stable[b] = hist[b][0];
        end
        m_sync2 = m_sync1;
        m_sync1 = raw_sensors;
    endtask

    initial model_reset();

    always @(posedge clock or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    always @(negedge clock) begin
        chk("sensors", int'(sensors), int'(m_sensors));
        chk("changed", int'(changed), int'(m_changed));
        chk("fault",   int'(fault),   int'(m_fault));
        chk("state",   int'(state),   m_fault ? 2 : (m_bad > 0 ? 1 : 0));
    end

    // ------------------------------------------------------------------
    // Directed scenarios with literal expectations
    // ------------------------------------------------------------------
    int nchg;
    int nsusp;
    int nbad;
    int nflt;

    initial begin
        // 1. reset with raw = 11, release, first change D+2 edges after sample
        raw_sensors = 2'b11;
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("t1_reset_sensors", int'(sensors), 0);
        chk("t1_reset_state",   int'(state),   0);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        chk("t1_edge5_sensors", int'(sensors), 0);
        @(negedge clock);
        chk("t1_edge6_sensors", int'(sensors), 3);
        chk("t1_edge6_changed", int'(changed), 1);
        @(negedge clock);
        chk("t1_edge7_changed", int'(changed), 0);

        // 2. glitch shorter than D is filtered; D cycles is accepted
        raw_sensors = 2'b00;
        repeat (12) @(negedge clock);
        chk("t2_base_sensors", int'(sensors), 0);
        raw_sensors = 2'b01;
        repeat (3) @(negedge clock);
        raw_sensors = 2'b00;
        nchg = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (changed) nchg++;
        end
        chk("t2_short_glitch_pulses",  nchg, 0);
        chk("t2_short_glitch_sensors", int'(sensors), 0);
        raw_sensors = 2'b01;
        nchg = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (changed) nchg++;
        end
        chk("t2_long_pulses",  nchg, 1);
        chk("t2_long_sensors", int'(sensors), 1);

        // 3. brief implausible pair: VALID -> SUSPECT -> VALID
        raw_sensors = 2'b10;
        nchg = 0; nsusp = 0; nbad = 0; nflt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) raw_sensors = 2'b11;
            @(negedge clock);
            if (changed)           nchg++;
            if (state == 2'd1)     nsusp++;
            if (sensors == 2'b10)  nbad++;
            if (fault)             nflt++;
        end
        chk("t3_suspect_cycles", nsusp, 5);
        chk("t3_pulses",         nchg,  1);
        chk("t3_never_10",       nbad,  0);
        chk("t3_no_fault",       nflt,  0);
        chk("t3_sensors",        int'(sensors), 3);

        raw_sensors = 2'b01;
        repeat (12) @(negedge clock);
        chk("t4_pre_sensors", int'(sensors), 1);

        // 4. persistent implausible pair faults exactly F cycles later
        raw_sensors = 2'b10;
        repeat (13) @(negedge clock);
        chk("t4_before_fault", int'(fault), 0);
        chk("t4_before_state", int'(state), 1);
        @(negedge clock);
        chk("t4_fault",         int'(fault),   1);
        chk("t4_fault_state",   int'(state),   2);
        chk("t4_fault_sensors", int'(sensors), 1);
        fault_clear = 1'b1;
        @(negedge clock);
        fault_clear = 1'b0;
        chk("t4_clear_ignored", int'(fault), 1);
        chk("t4_clear_state",   int'(state), 2);

        // 5. plausible pair plus fault_clear releases the fault
        raw_sensors = 2'b00;
        repeat (6) @(negedge clock);
        chk("t5_still_fault", int'(fault), 1);
        fault_clear = 1'b1;
        @(negedge clock);
        fault_clear = 1'b0;
        chk("t5_state",   int'(state),   0);
        chk("t5_fault",   int'(fault),   0);
        chk("t5_sensors", int'(sensors), 0);
        chk("t5_changed", int'(changed), 1);
        @(negedge clock);
        chk("t5_changed_end", int'(changed), 0);

        // 6. asynchronous reset while SUSPECT is mid-count
        raw_sensors = 2'b01;
        repeat (12) @(negedge clock);
        chk("t6_pre_sensors", int'(sensors), 1);
        raw_sensors = 2'b10;
        repeat (9) @(negedge clock);
        chk("t6_suspect", int'(state), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_sensors", int'(sensors), 0);
        chk("t6_async_fault",   int'(fault),   0);
        chk("t6_async_state",   int'(state),   0);
        @(negedge clock);
        raw_sensors = 2'b00;
        reset = 1'b1;
        nchg = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (changed) nchg++;
        end
        chk("t6_no_pulse",     nchg, 0);
        chk("t6_post_sensors", int'(sensors), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
